// File: rtl/l2_request_arbiter_pkg.sv
// Shared constants for the core->L2 request arbiter: unit ids, L2 request
// opcodes, strand index width and a one-hot to index helper.
package l2_request_arbiter_pkg;

    // Requesting unit ids; the id is also the unit's slice index on the inputs.
    localparam int UNIT_ICACHE = 0;
    localparam int UNIT_DCACHE = 1;
    localparam int UNIT_STBUF  = 2;

    localparam int STRAND_INDEX_WIDTH = 5;

    // L2 request opcodes carried on the op field.
    localparam logic [2:0] L2REQ_LOAD  = 3'd0;
    localparam logic [2:0] L2REQ_STORE = 3'd1;

    // Index of the set bit in a one-hot vector; zero when no bit is set.
    function automatic logic [4:0] one_hot_to_index(input logic [31:0] one_hot);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (one_hot[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/l2_request_arbiter_rr.sv
// Round-robin arbiter. Search starts at the pointer; the pointer moves to one
// past the winner only when update_lru says the grant was consumed.
module l2_request_arbiter_rr
    import l2_request_arbiter_pkg::*;
#(
    parameter int NUM_ENTRIES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_ENTRIES-1:0] request,
    input  logic                   update_lru,
    output logic [NUM_ENTRIES-1:0] grant_oh
);

    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner_idx;
    logic [IDX_W-1:0] cand;
    logic             found;

    // First requester at or after the pointer, wrapping, wins.
    always_comb begin
        grant_oh = '0;
        cand     = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % NUM_ENTRIES);
            if (!found && request[cand]) begin
                grant_oh[cand] = 1'b1;
                found          = 1'b1;
            end
        end
    end

    assign winner_idx = IDX_W'(one_hot_to_index(32'(grant_oh)));

    // Pointer advances past the consumed winner, wrapping to entry 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (update_lru) begin
            if (int'(winner_idx) == NUM_ENTRIES - 1) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= winner_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/l2_request_arbiter.sv
// Merges icache, dcache and store buffer L2 request streams onto the single
// core->L2 request port through a one-entry output register.
// Optional feature macro: L2_ARB_PERF_EN adds per-unit accept counters and a
// stall-cycle counter.
//
// Handshake: a unit's request transfers in a cycle where unit_valid[i] and
// unit_ready[i] are both high; the unit holds valid and fields stable until
// then and never retracts. The held request transfers to L2 in a cycle where
// l2req_valid and l2req_ready are both high; the slot refills in that same
// cycle, so one request per cycle is sustained.
module l2_request_arbiter
    import l2_request_arbiter_pkg::*;
#(
    parameter int NUM_UNITS  = 3,
    parameter int ADDR_WIDTH = 26
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_UNITS-1:0]                    unit_valid,
    output logic [NUM_UNITS-1:0]                    unit_ready,
    input  logic [NUM_UNITS*STRAND_INDEX_WIDTH-1:0] unit_strand,
    input  logic [NUM_UNITS*3-1:0]                  unit_op,
    input  logic [NUM_UNITS*2-1:0]                  unit_way,
    input  logic [NUM_UNITS*ADDR_WIDTH-1:0]         unit_address,
    input  logic [NUM_UNITS*512-1:0]                unit_data,
    input  logic [NUM_UNITS*64-1:0]                 unit_mask,
    output logic                                    l2req_valid,
    input  logic                                    l2req_ready,
    output logic [1:0]                              l2req_unit,
    output logic [STRAND_INDEX_WIDTH-1:0]           l2req_strand,
    output logic [2:0]                              l2req_op,
    output logic [1:0]                              l2req_way,
    output logic [ADDR_WIDTH-1:0]                   l2req_address,
    output logic [511:0]                            l2req_data,
    output logic [63:0]                             l2req_mask
`ifdef L2_ARB_PERF_EN
    ,
    output logic [NUM_UNITS*32-1:0]                 perf_accept_count,
    output logic [31:0]                             perf_stall_count
`endif
);

    logic                          slot_free;
    logic                          accept;
    logic [NUM_UNITS-1:0]          grant_oh;
    logic [1:0]                    win_unit;
    logic [STRAND_INDEX_WIDTH-1:0] sel_strand;
    logic [2:0]                    sel_op;
    logic [1:0]                    sel_way;
    logic [ADDR_WIDTH-1:0]         sel_address;
    logic [511:0]                  sel_data;
    logic [63:0]                   sel_mask;

    // The slot can take a new request when empty or draining this cycle.
    assign slot_free  = !l2req_valid || l2req_ready;
    assign unit_ready = grant_oh & {NUM_UNITS{slot_free}} & {NUM_UNITS{!reset}};
    assign accept     = |unit_ready;
    assign win_unit   = 2'(one_hot_to_index(32'(grant_oh)));

    l2_request_arbiter_rr #(
        .NUM_ENTRIES (NUM_UNITS)
    ) u_arbiter (
        .clk        (clk),
        .reset      (reset),
        .request    (unit_valid),
        .update_lru (accept),
        .grant_oh   (grant_oh)
    );

    // Select the granted unit's fields; grant_oh is one-hot or zero.
    always_comb begin
        sel_strand  = '0;
        sel_op      = '0;
        sel_way     = '0;
        sel_address = '0;
        sel_data    = '0;
        sel_mask    = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (grant_oh[i]) begin
                sel_strand  = unit_strand[i*STRAND_INDEX_WIDTH +: STRAND_INDEX_WIDTH];
                sel_op      = unit_op[i*3 +: 3];
                sel_way     = unit_way[i*2 +: 2];
                sel_address = unit_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data    = unit_data[i*512 +: 512];
                sel_mask    = unit_mask[i*64 +: 64];
            end
        end
    end

    // One-entry output register: load on accept, empty when drained without refill.
    always_ff @(posedge clk) begin
        if (reset) begin
            l2req_valid   <= 1'b0;
            l2req_unit    <= '0;
            l2req_strand  <= '0;
            l2req_op      <= '0;
            l2req_way     <= '0;
            l2req_address <= '0;
            l2req_data    <= '0;
            l2req_mask    <= '0;
        end else if (accept) begin
            l2req_valid   <= 1'b1;
            l2req_unit    <= win_unit;
            l2req_strand  <= sel_strand;
            l2req_op      <= sel_op;
            l2req_way     <= sel_way;
            l2req_address <= sel_address;
            l2req_data    <= sel_data;
            l2req_mask    <= sel_mask;
        end else if (l2req_ready) begin
            l2req_valid <= 1'b0;
        end
    end

`ifdef L2_ARB_PERF_EN
    // Per-unit accept counts and stall-cycle count, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_accept_count <= '0;
            perf_stall_count  <= '0;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (unit_ready[i]) begin
                    perf_accept_count[i*32 +: 32] <= perf_accept_count[i*32 +: 32] + 32'd1;
                end
            end
            if (l2req_valid && !l2req_ready) begin
                perf_stall_count <= perf_stall_count + 32'd1;
            end
        end
    end
`endif

    // A unit may not drop a request that has not been accepted.
    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_no_retract
        assert property (@(posedge clk) disable iff (reset)
            (unit_valid[g] && !unit_ready[g]) |=> unit_valid[g]);
    end

endmodule

// File: tb/tb_l2_request_arbiter.sv
module tb_l2_request_arbiter;
    import l2_request_arbiter_pkg::*;

    localparam int NU = 3;
    localparam int AW = 26;
    localparam int SW = STRAND_INDEX_WIDTH;
    localparam int NV = 17;

    logic             clk = 1'b0;
    logic             reset;
    logic [NU-1:0]    unit_valid;
    logic [NU-1:0]    unit_ready;
    logic [NU*SW-1:0] unit_strand;
    logic [NU*3-1:0]  unit_op;
    logic [NU*2-1:0]  unit_way;
    logic [NU*AW-1:0] unit_address;
    logic [NU*512-1:0] unit_data;
    logic [NU*64-1:0] unit_mask;
    logic             l2req_valid;
    logic             l2req_ready;
    logic [1:0]       l2req_unit;
    logic [SW-1:0]    l2req_strand;
    logic [2:0]       l2req_op;
    logic [1:0]       l2req_way;
    logic [AW-1:0]    l2req_address;
    logic [511:0]     l2req_data;
    logic [63:0]      l2req_mask;
`ifdef L2_ARB_PERF_EN
    logic [NU*32-1:0] perf_accept_count;
    logic [31:0]      perf_stall_count;
`endif

    l2_request_arbiter #(
        .NUM_UNITS  (NU),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .unit_valid    (unit_valid),
        .unit_ready    (unit_ready),
        .unit_strand   (unit_strand),
        .unit_op       (unit_op),
        .unit_way      (unit_way),
        .unit_address  (unit_address),
        .unit_data     (unit_data),
        .unit_mask     (unit_mask),
        .l2req_valid   (l2req_valid),
        .l2req_ready   (l2req_ready),
        .l2req_unit    (l2req_unit),
        .l2req_strand  (l2req_strand),
        .l2req_op      (l2req_op),
        .l2req_way     (l2req_way),
        .l2req_address (l2req_address),
        .l2req_data    (l2req_data),
        .l2req_mask    (l2req_mask)
`ifdef L2_ARB_PERF_EN
        ,
        .perf_accept_count (perf_accept_count),
        .perf_stall_count  (perf_stall_count)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    // per-unit request fields, constant for the whole run
    logic [SW-1:0]  u_strand[NU];
    logic [2:0]     u_op[NU];
    logic [1:0]     u_way[NU];
    logic [AW-1:0]  u_addr[NU];
    logic [511:0]   u_data[NU];
    logic [63:0]    u_mask[NU];

    typedef struct {
        logic [NU-1:0] valid;
        logic          rdy;
        logic [NU-1:0] exp_ur;
        logic          exp_v;
        logic [1:0]    exp_unit;
    } vec_t;

    vec_t vecs[NV];

    // scoreboard
    logic [AW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_fields(input string tag, input logic [1:0] u);
        check({tag, " unit"},   512'(l2req_unit),    512'(u));
        check({tag, " strand"}, 512'(l2req_strand),  512'(u_strand[u]));
        check({tag, " op"},     512'(l2req_op),      512'(u_op[u]));
        check({tag, " way"},    512'(l2req_way),     512'(u_way[u]));
        check({tag, " addr"},   512'(l2req_address), 512'(u_addr[u]));
        check({tag, " data"},   l2req_data,          u_data[u]);
        check({tag, " mask"},   512'(l2req_mask),    512'(u_mask[u]));
    endtask

    // driver: apply inputs, check combinational ready mid-cycle, then the register after the edge
    task automatic drive_cycle(input string tag, input logic [NU-1:0] v, input logic r,
                               input logic [NU-1:0] exp_ur, input logic exp_v, input logic [1:0] exp_unit);
        logic [AW-1:0] exp_a;
        unit_valid  = v;
        l2req_ready = r;
        @(negedge clk);
        check({tag, " unit_ready"}, 512'(unit_ready), 512'(exp_ur));
        if (exp_ur != '0) begin
            exp_q.push_back(u_addr[exp_unit]);
        end
        @(posedge clk);
        #1;
        check({tag, " l2req_valid"}, 512'(l2req_valid), 512'(exp_v));
        if (exp_v) begin
            check_fields(tag, exp_unit);
        end
        if (exp_ur != '0 && exp_q.size() > 0) begin
            exp_a = exp_q.pop_front();
            check({tag, " sb addr"}, 512'(l2req_address), 512'(exp_a));
        end
    endtask

    initial begin
        u_strand[0] = 5'd3;  u_strand[1] = 5'd7;  u_strand[2] = 5'd17;
        u_op[0] = L2REQ_LOAD; u_op[1] = L2REQ_LOAD; u_op[2] = L2REQ_STORE;
        u_way[0] = 2'd1; u_way[1] = 2'd2; u_way[2] = 2'd3;
        u_addr[0] = 26'h00AAAA; u_addr[1] = 26'h015555; u_addr[2] = 26'h12345;
        u_data[0] = {16{32'hC0DE_0001}};
        u_data[1] = {16{32'hBEEF_0002}};
        u_data[2] = {16{32'h5A5A_0003}};
        u_mask[0] = 64'hFFFF_0000_FFFF_0000;
        u_mask[1] = 64'h0000_FFFF_0000_FFFF;
        u_mask[2] = 64'hF0F0_F0F0_0F0F_0F0F;
        unit_strand  = {u_strand[2], u_strand[1], u_strand[0]};
        unit_op      = {u_op[2], u_op[1], u_op[0]};
        unit_way     = {u_way[2], u_way[1], u_way[0]};
        unit_address = {u_addr[2], u_addr[1], u_addr[0]};
        unit_data    = {u_data[2], u_data[1], u_data[0]};
        unit_mask    = {u_mask[2], u_mask[1], u_mask[0]};

        //            valid    rdy   exp_ur  exp_v exp_unit
        // single stbuf store
        vecs[0]  = '{3'b100, 1'b1, 3'b100, 1'b1, 2'd2};
        // drain with no new requests; pointer stays at 0
        vecs[1]  = '{3'b000, 1'b1, 3'b000, 1'b0, 2'd0};
        // all units valid: 0,1,2,0,1,2 back to back
        vecs[2]  = '{3'b111, 1'b1, 3'b001, 1'b1, 2'd0};
        vecs[3]  = '{3'b111, 1'b1, 3'b010, 1'b1, 2'd1};
        vecs[4]  = '{3'b111, 1'b1, 3'b100, 1'b1, 2'd2};
        vecs[5]  = '{3'b111, 1'b1, 3'b001, 1'b1, 2'd0};
        vecs[6]  = '{3'b111, 1'b1, 3'b010, 1'b1, 2'd1};
        vecs[7]  = '{3'b111, 1'b1, 3'b100, 1'b1, 2'd2};
        // get a dcache request into the output register
        vecs[8]  = '{3'b011, 1'b1, 3'b001, 1'b1, 2'd0};
        vecs[9]  = '{3'b010, 1'b1, 3'b010, 1'b1, 2'd1};
        // four stall cycles with waiters: held dcache request frozen
        vecs[10] = '{3'b101, 1'b0, 3'b000, 1'b1, 2'd1};
        vecs[11] = '{3'b101, 1'b0, 3'b000, 1'b1, 2'd1};
        vecs[12] = '{3'b101, 1'b0, 3'b000, 1'b1, 2'd1};
        vecs[13] = '{3'b101, 1'b0, 3'b000, 1'b1, 2'd1};
        // ready returns: next waiter (pointer at 2) accepted same cycle
        vecs[14] = '{3'b101, 1'b1, 3'b100, 1'b1, 2'd2};
        vecs[15] = '{3'b001, 1'b1, 3'b001, 1'b1, 2'd0};
        // leave a request held under stall for the reset test
        vecs[16] = '{3'b000, 1'b0, 3'b000, 1'b1, 2'd0};

        // reset
        reset       = 1'b1;
        unit_valid  = 3'b111;
        l2req_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset unit_ready", 512'(unit_ready), 512'(3'b000));
        @(posedge clk);
        #1;
        check("reset l2req_valid", 512'(l2req_valid), 512'(1'b0));
        check("reset l2req_unit", 512'(l2req_unit), 512'(2'd0));
        check("reset l2req_address", 512'(l2req_address), 512'(26'h0));
        check("reset l2req_data", l2req_data, 512'(0));
        reset = 1'b0;

        for (int k = 0; k < NV; k++) begin
            drive_cycle($sformatf("vec%0d", k), vecs[k].valid, vecs[k].rdy,
                        vecs[k].exp_ur, vecs[k].exp_v, vecs[k].exp_unit);
        end

        // reset while a request is held and stalled; pointer was at 1
        reset       = 1'b1;
        unit_valid  = 3'b011;
        l2req_ready = 1'b0;
        @(negedge clk);
        check("midreset unit_ready", 512'(unit_ready), 512'(3'b000));
        @(posedge clk);
        #1;
        check("midreset l2req_valid", 512'(l2req_valid), 512'(1'b0));
        check("midreset l2req_address", 512'(l2req_address), 512'(26'h0));
        reset = 1'b0;
        // pointer back at 0: lowest valid unit wins
        drive_cycle("postreset0", 3'b011, 1'b0, 3'b001, 1'b1, 2'd0);
        drive_cycle("postreset1", 3'b010, 1'b1, 3'b010, 1'b1, 2'd1);
        drive_cycle("postreset2", 3'b000, 1'b1, 3'b000, 1'b0, 2'd0);

`ifdef L2_ARB_PERF_EN
        // ten stbuf accepts then three stall cycles
        reset = 1'b1;
        unit_valid  = 3'b000;
        l2req_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("perf reset stall", 512'(perf_stall_count), 512'(0));
        for (int k = 0; k < 10; k++) begin
            drive_cycle($sformatf("perf acc%0d", k), 3'b100, 1'b1, 3'b100, 1'b1, 2'd2);
        end
        for (int k = 0; k < 3; k++) begin
            drive_cycle($sformatf("perf stall%0d", k), 3'b000, 1'b0, 3'b000, 1'b1, 2'd2);
        end
        check("perf accept stbuf", 512'(perf_accept_count[64 +: 32]), 512'(32'd10));
        check("perf accept icache", 512'(perf_accept_count[0 +: 32]), 512'(32'd0));
        check("perf accept dcache", 512'(perf_accept_count[32 +: 32]), 512'(32'd0));
        check("perf stall", 512'(perf_stall_count), 512'(32'd3));
`endif

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
